// File: rtl/fwd_bypass_net_pkg.sv
// Shared widths and helpers for the operand bypass network.
package fwd_bypass_net_pkg;
  localparam int ZCRV_REG_SIZE = 5;
  localparam int ZCRV_XLEN     = 32;
  localparam int STALL_CW      = 16;
  localparam logic [STALL_CW-1:0] STALL_MAX = '1;

  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v,
                                                  input logic en);
    return (en && (v != STALL_MAX)) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/fwd_lookup.sv
// Priority match of one source port against the tracked entries (lowest index wins).
// FWD_LD_BYPASS_EN: a pending winner at LD_STG takes ld_data in the same cycle.
module fwd_lookup
  import fwd_bypass_net_pkg::*;
#(
  parameter int XLEN   = ZCRV_XLEN,
  parameter int REG_AW = ZCRV_REG_SIZE,
  parameter int DEPTH  = 3,
  parameter int LD_STG = 1
) (
  input  logic                     i_en,
  input  logic [REG_AW-1:0]        i_addr,
  input  logic [DEPTH-1:0]         i_vld,
  input  logic [DEPTH-1:0]         i_dvld,
  input  logic [DEPTH*REG_AW-1:0]  i_rd,
  input  logic [DEPTH*XLEN-1:0]    i_data,
  input  logic                     i_ld_done,
  input  logic [XLEN-1:0]          i_ld_data,
  output logic                     o_hit,
  output logic                     o_pend,
  output logic [XLEN-1:0]          o_data
);
  logic [DEPTH-1:0] w_match;
  logic             w_any;
  logic             w_sel_dvld;
  logic             w_sel_ld;
  logic [XLEN-1:0]  w_sel_data;
  logic             w_byp;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_match[gi] = i_en && (i_addr != '0) && i_vld[gi] &&
                         (i_rd[gi*REG_AW +: REG_AW] == i_addr);
  end

  // Walk oldest to youngest so the youngest match overwrites the selection.
  always_comb begin
    w_any      = 1'b0;
    w_sel_dvld = 1'b0;
    w_sel_ld   = 1'b0;
    w_sel_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_any      = 1'b1;
        w_sel_dvld = i_dvld[i];
        w_sel_ld   = (i == LD_STG);
        w_sel_data = i_data[i*XLEN +: XLEN];
      end
    end
  end

`ifdef FWD_LD_BYPASS_EN
  assign w_byp = w_any & ~w_sel_dvld & w_sel_ld & i_ld_done;
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{i_ld_done, i_ld_data, w_sel_ld};
  assign w_byp       = 1'b0;
`endif

  assign o_hit  = w_any & (w_sel_dvld | w_byp);
  assign o_pend = w_any & ~w_sel_dvld & ~w_byp;
  assign o_data = !o_hit ? '0 : (w_byp ? i_ld_data : w_sel_data);
endmodule

// File: rtl/fwd_bypass_net.sv
// Multi-stage operand bypass network: in-flight write tracking, forwarding, load-use stall.
// Optional macro FWD_LD_BYPASS_EN enables same-cycle forwarding of ld_data.
module fwd_bypass_net
  import fwd_bypass_net_pkg::*;
#(
  parameter int XLEN      = ZCRV_XLEN,
  parameter int REG_AW    = ZCRV_REG_SIZE,
  parameter int NUM_SRC   = 2,
  parameter int DEPTH     = 3,
  parameter int LD_STG    = 1,
  parameter int FLUSH_STG = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_pipe_adv,
  input  logic                      i_flush,
  input  logic                      i_ins_en,
  input  logic [REG_AW-1:0]         i_ins_rd,
  input  logic [XLEN-1:0]           i_ins_data,
  input  logic                      i_ins_dvld,
  input  logic                      i_ld_done,
  input  logic [XLEN-1:0]           i_ld_data,
  input  logic [NUM_SRC-1:0]        i_rs_en,
  input  logic [NUM_SRC*REG_AW-1:0] i_rs_addr,
  output logic [NUM_SRC-1:0]        o_fwd_hit,
  output logic [NUM_SRC*XLEN-1:0]   o_fwd_data,
  output logic                      o_haz_stall,
  output logic [STALL_CW-1:0]       o_stall_cnt
);
  logic [DEPTH-1:0]        r_vld, r_dvld;
  logic [DEPTH*REG_AW-1:0] r_rd;
  logic [DEPTH*XLEN-1:0]   r_data;
  logic [STALL_CW-1:0]     r_stall_cnt;

  logic                    w_fill, w_alloc;
  logic [DEPTH-1:0]        w_fdvld;
  logic [DEPTH*XLEN-1:0]   w_fdata;
  logic [DEPTH-1:0]        w_vld_next, w_dvld_next;
  logic [DEPTH*REG_AW-1:0] w_rd_next;
  logic [DEPTH*XLEN-1:0]   w_data_next;
  logic [NUM_SRC-1:0]      w_pend;

  assign w_fill  = i_ld_done & r_vld[LD_STG] & ~r_dvld[LD_STG];
  assign w_alloc = i_ins_en & ~i_flush & (i_ins_rd != '0);

  // Fill first, then shift, so a fill during an advance lands one stage older.
  always_comb begin
    w_fdvld = r_dvld;
    w_fdata = r_data;
    if (w_fill) begin
      w_fdvld[LD_STG]                = 1'b1;
      w_fdata[LD_STG*XLEN +: XLEN]   = i_ld_data;
    end
  end

  always_comb begin
    w_vld_next  = r_vld;
    w_dvld_next = w_fdvld;
    w_rd_next   = r_rd;
    w_data_next = w_fdata;
    if (i_pipe_adv) begin
      w_vld_next  = {r_vld[DEPTH-2:0], w_alloc};
      w_dvld_next = {w_fdvld[DEPTH-2:0], i_ins_dvld};
      w_rd_next   = {r_rd[(DEPTH-1)*REG_AW-1:0], i_ins_rd};
      w_data_next = {w_fdata[(DEPTH-1)*XLEN-1:0], i_ins_data};
    end
    if (i_flush) begin
      for (int i = 0; i < FLUSH_STG; i++) w_vld_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_dvld      <= '0;
      r_rd        <= '0;
      r_data      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_vld       <= w_vld_next;
      r_dvld      <= w_dvld_next;
      r_rd        <= w_rd_next;
      r_data      <= w_data_next;
      r_stall_cnt <= sat_inc(r_stall_cnt, o_haz_stall);
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_port
    fwd_lookup #(
      .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .LD_STG(LD_STG)
    ) u_lookup (
      .i_en      (i_rs_en[gi]),
      .i_addr    (i_rs_addr[gi*REG_AW +: REG_AW]),
      .i_vld     (r_vld),
      .i_dvld    (r_dvld),
      .i_rd      (r_rd),
      .i_data    (r_data),
      .i_ld_done (i_ld_done),
      .i_ld_data (i_ld_data),
      .o_hit     (o_fwd_hit[gi]),
      .o_pend    (w_pend[gi]),
      .o_data    (o_fwd_data[gi*XLEN +: XLEN])
    );
  end

  assign o_haz_stall = |w_pend;
  assign o_stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_fwd_bypass_net.sv
// Self-checking bench for fwd_bypass_net; per-scenario tasks with a scoreboard queue.
module tb_fwd_bypass_net;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_adv = 1'b0, flush = 1'b0, ins_en = 1'b0, ins_dvld = 1'b0, ld_done = 1'b0;
  logic [4:0]  ins_rd = '0;
  logic [31:0] ins_data = '0, ld_data = '0;
  logic [1:0]  rs_en = 2'b11;
  logic [9:0]  rs_addr = '0;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic        haz_stall;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_cnt = '0;

  typedef struct {
    logic        rst_n, adv, ins_en, dvld, flush, ld_done;
    logic [4:0]  rd, rs0, rs1;
    logic [31:0] data, ld_data;
    logic [1:0]  rs_en;
    logic [1:0]  hit;
    logic [31:0] d0, d1;
    logic        stall;
  } txn_t;

  txn_t sb[$];

  fwd_bypass_net dut (
    .clk(clk), .rst_n(rst_n), .i_pipe_adv(pipe_adv), .i_flush(flush),
    .i_ins_en(ins_en), .i_ins_rd(ins_rd), .i_ins_data(ins_data), .i_ins_dvld(ins_dvld),
    .i_ld_done(ld_done), .i_ld_data(ld_data), .i_rs_en(rs_en), .i_rs_addr(rs_addr),
    .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data), .o_haz_stall(haz_stall),
    .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk(logic r, logic adv, logic ie, logic [4:0] rd, logic [31:0] d,
                              logic dv, logic fl, logic ld, logic [31:0] ldd, logic [1:0] en,
                              logic [4:0] s0, logic [4:0] s1, logic [1:0] h,
                              logic [31:0] e0, logic [31:0] e1, logic st);
    txn_t t;
    t.rst_n = r; t.adv = adv; t.ins_en = ie; t.rd = rd; t.data = d; t.dvld = dv;
    t.flush = fl; t.ld_done = ld; t.ld_data = ldd; t.rs_en = en; t.rs0 = s0; t.rs1 = s1;
    t.hit = h; t.d0 = e0; t.d1 = e1; t.stall = st;
    return t;
  endfunction

  task automatic apply(input txn_t t);
    @(negedge clk);
    rst_n = t.rst_n; pipe_adv = t.adv; ins_en = t.ins_en; ins_rd = t.rd;
    ins_data = t.data; ins_dvld = t.dvld; flush = t.flush; ld_done = t.ld_done;
    ld_data = t.ld_data; rs_en = t.rs_en; rs_addr = {t.rs1, t.rs0};
    if (!t.rst_n) sb_cnt = '0;
    #1;
  endtask

  task automatic test_reset();
    txn_t t;
    int   n = 0;
    sb.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,5,6, 2'b00,0,0,0));
    sb.push_back(mk(0,1,1,5,32'h77,1,0,0,0,2'b11,5,6, 2'b00,0,0,0));
    while (sb.size() > 0) begin
      t = sb.pop_front(); apply(t); n++;
      checks += 5;
      if (fwd_hit !== t.hit) begin errors++; $display("FAIL reset[%0d] hit got=%b want=%b", n, fwd_hit, t.hit); end
      if (fwd_data[31:0] !== t.d0) begin errors++; $display("FAIL reset[%0d] data0 got=%h want=%h", n, fwd_data[31:0], t.d0); end
      if (fwd_data[63:32] !== t.d1) begin errors++; $display("FAIL reset[%0d] data1 got=%h want=%h", n, fwd_data[63:32], t.d1); end
      if (haz_stall !== t.stall) begin errors++; $display("FAIL reset[%0d] stall got=%b want=%b", n, haz_stall, t.stall); end
      if (stall_cnt !== sb_cnt) begin errors++; $display("FAIL reset[%0d] cnt got=%0d want=%0d", n, stall_cnt, sb_cnt); end
      $display("reset[%0d] hit=%b d0=%h stall=%b cnt=%0d", n, fwd_hit, fwd_data[31:0], haz_stall, stall_cnt);
    end
  endtask

  task automatic test_forward();
    txn_t t;
    int   n = 0;
    sb.push_back(mk(1,1,1,5,32'hA5A5,1,0,0,0,2'b11,5,6, 2'b00,0,0,0));
    sb.push_back(mk(1,1,1,5,32'h1234,1,0,0,0,2'b11,5,6, 2'b01,32'hA5A5,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b01,5,5, 2'b01,32'h1234,0,0));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,5,5, 2'b11,32'h1234,32'h1234,0));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,5,6, 2'b01,32'h1234,0,0));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,5,6, 2'b01,32'h1234,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,5,6, 2'b00,0,0,0));
    while (sb.size() > 0) begin
      t = sb.pop_front(); apply(t); n++;
      checks += 5;
      if (fwd_hit !== t.hit) begin errors++; $display("FAIL fwd[%0d] hit got=%b want=%b", n, fwd_hit, t.hit); end
      if (fwd_data[31:0] !== t.d0) begin errors++; $display("FAIL fwd[%0d] data0 got=%h want=%h", n, fwd_data[31:0], t.d0); end
      if (fwd_data[63:32] !== t.d1) begin errors++; $display("FAIL fwd[%0d] data1 got=%h want=%h", n, fwd_data[63:32], t.d1); end
      if (haz_stall !== t.stall) begin errors++; $display("FAIL fwd[%0d] stall got=%b want=%b", n, haz_stall, t.stall); end
      if (stall_cnt !== sb_cnt) begin errors++; $display("FAIL fwd[%0d] cnt got=%0d want=%0d", n, stall_cnt, sb_cnt); end
      $display("fwd[%0d] hit=%b d0=%h d1=%h stall=%b", n, fwd_hit, fwd_data[31:0], fwd_data[63:32], haz_stall);
      if (sb_cnt != 16'hFFFF && t.stall) sb_cnt = sb_cnt + 16'd1;
    end
  endtask

  task automatic test_load_use();
    txn_t t;
    int   n = 0;
    sb.push_back(mk(1,1,1,7,32'h1111,1,0,0,0,2'b11,7,6, 2'b00,0,0,0));
    sb.push_back(mk(1,1,1,7,32'h0,0,0,0,0,2'b11,7,6, 2'b01,32'h1111,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,7,6, 2'b00,0,0,1));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,7,6, 2'b00,0,0,1));
`ifdef FWD_LD_BYPASS_EN
    sb.push_back(mk(1,1,0,0,0,0,0,1,32'hDEAD,2'b11,7,6, 2'b01,32'hDEAD,0,0));
`else
    sb.push_back(mk(1,1,0,0,0,0,0,1,32'hDEAD,2'b11,7,6, 2'b00,0,0,1));
`endif
    sb.push_back(mk(1,0,0,0,0,0,0,1,32'hBEEF,2'b11,7,6, 2'b01,32'hDEAD,0,0));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,7,6, 2'b01,32'hDEAD,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,7,6, 2'b00,0,0,0));
    while (sb.size() > 0) begin
      t = sb.pop_front(); apply(t); n++;
      checks += 5;
      if (fwd_hit !== t.hit) begin errors++; $display("FAIL load[%0d] hit got=%b want=%b", n, fwd_hit, t.hit); end
      if (fwd_data[31:0] !== t.d0) begin errors++; $display("FAIL load[%0d] data0 got=%h want=%h", n, fwd_data[31:0], t.d0); end
      if (fwd_data[63:32] !== t.d1) begin errors++; $display("FAIL load[%0d] data1 got=%h want=%h", n, fwd_data[63:32], t.d1); end
      if (haz_stall !== t.stall) begin errors++; $display("FAIL load[%0d] stall got=%b want=%b", n, haz_stall, t.stall); end
      if (stall_cnt !== sb_cnt) begin errors++; $display("FAIL load[%0d] cnt got=%0d want=%0d", n, stall_cnt, sb_cnt); end
      $display("load[%0d] hit=%b d0=%h stall=%b cnt=%0d", n, fwd_hit, fwd_data[31:0], haz_stall, stall_cnt);
      if (sb_cnt != 16'hFFFF && t.stall) sb_cnt = sb_cnt + 16'd1;
    end
  endtask

  task automatic test_x0_flush();
    txn_t t;
    int   n = 0;
    sb.push_back(mk(1,1,1,0,32'hFF,1,0,0,0,2'b11,0,0, 2'b00,0,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,0,0, 2'b00,0,0,0));
    sb.push_back(mk(1,1,1,9,32'h99,1,0,0,0,2'b11,3,9, 2'b00,0,0,0));
    sb.push_back(mk(1,1,1,3,32'h33,1,1,0,0,2'b11,3,9, 2'b10,0,32'h99,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,3,9, 2'b10,0,32'h99,0));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,3,9, 2'b10,0,32'h99,0));
    sb.push_back(mk(1,1,0,0,0,0,0,0,0,2'b11,3,9, 2'b10,0,32'h99,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,3,9, 2'b00,0,0,0));
    while (sb.size() > 0) begin
      t = sb.pop_front(); apply(t); n++;
      checks += 5;
      if (fwd_hit !== t.hit) begin errors++; $display("FAIL flush[%0d] hit got=%b want=%b", n, fwd_hit, t.hit); end
      if (fwd_data[31:0] !== t.d0) begin errors++; $display("FAIL flush[%0d] data0 got=%h want=%h", n, fwd_data[31:0], t.d0); end
      if (fwd_data[63:32] !== t.d1) begin errors++; $display("FAIL flush[%0d] data1 got=%h want=%h", n, fwd_data[63:32], t.d1); end
      if (haz_stall !== t.stall) begin errors++; $display("FAIL flush[%0d] stall got=%b want=%b", n, haz_stall, t.stall); end
      if (stall_cnt !== sb_cnt) begin errors++; $display("FAIL flush[%0d] cnt got=%0d want=%0d", n, stall_cnt, sb_cnt); end
      $display("flush[%0d] hit=%b d0=%h d1=%h stall=%b", n, fwd_hit, fwd_data[31:0], fwd_data[63:32], haz_stall);
      if (sb_cnt != 16'hFFFF && t.stall) sb_cnt = sb_cnt + 16'd1;
    end
  endtask

  task automatic test_hold_reset();
    txn_t t;
    int   n = 0;
    sb.push_back(mk(1,1,1,10,32'hAAAA,1,0,0,0,2'b11,10,11, 2'b00,0,0,0));
    for (int k = 0; k < 4; k++)
      sb.push_back(mk(1,0,1,10,32'hBBBB,1,0,0,0,2'b11,10,11, 2'b01,32'hAAAA,0,0));
    sb.push_back(mk(1,1,1,11,32'h0,0,0,0,0,2'b11,10,11, 2'b01,32'hAAAA,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,10,11, 2'b01,32'hAAAA,0,1));
    sb.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,10,11, 2'b00,0,0,0));
    sb.push_back(mk(1,0,0,0,0,0,0,0,0,2'b11,10,11, 2'b00,0,0,0));
    while (sb.size() > 0) begin
      t = sb.pop_front(); apply(t); n++;
      checks += 5;
      if (fwd_hit !== t.hit) begin errors++; $display("FAIL hold[%0d] hit got=%b want=%b", n, fwd_hit, t.hit); end
      if (fwd_data[31:0] !== t.d0) begin errors++; $display("FAIL hold[%0d] data0 got=%h want=%h", n, fwd_data[31:0], t.d0); end
      if (fwd_data[63:32] !== t.d1) begin errors++; $display("FAIL hold[%0d] data1 got=%h want=%h", n, fwd_data[63:32], t.d1); end
      if (haz_stall !== t.stall) begin errors++; $display("FAIL hold[%0d] stall got=%b want=%b", n, haz_stall, t.stall); end
      if (stall_cnt !== sb_cnt) begin errors++; $display("FAIL hold[%0d] cnt got=%0d want=%0d", n, stall_cnt, sb_cnt); end
      $display("hold[%0d] rst_n=%b hit=%b d0=%h stall=%b cnt=%0d", n, rst_n, fwd_hit, fwd_data[31:0], haz_stall, stall_cnt);
      if (t.rst_n && sb_cnt != 16'hFFFF && t.stall) sb_cnt = sb_cnt + 16'd1;
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    pipe_adv = 1'b1; ins_en = 1'b1; ins_rd = 5'd12; ins_dvld = 1'b0; ins_data = '0;
    flush = 1'b0; ld_done = 1'b0; rs_en = 2'b01; rs_addr = {5'd0, 5'd12};
    #1;
    checks++;
    if (haz_stall !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL sat_start stall=%b cnt=%0d want stall=0 cnt=0", haz_stall, stall_cnt);
    end
    @(negedge clk);
    pipe_adv = 1'b0; ins_en = 1'b0;
    repeat (65534) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got=%h want=fffe", stall_cnt); end
    $display("sat_near stall=%b cnt=%h", haz_stall, stall_cnt);
    repeat (5) @(negedge clk);
    #1;
    checks += 2;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt); end
    if (haz_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got=%b want=1", haz_stall); end
    $display("sat_hold stall=%b cnt=%h", haz_stall, stall_cnt);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || haz_stall !== 1'b0) begin
      errors++; $display("FAIL sat_reset cnt=%0d stall=%b want 0/0", stall_cnt, haz_stall);
    end
    $display("sat_reset stall=%b cnt=%h", haz_stall, stall_cnt);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_x0_flush();
    test_hold_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
